// File: rtl/trig_counter_bank.sv
// Bank of NUM_CH up/down counters with shared prescaler, sticky terminal-count flags and a registered read mux.
// Define COUNTER_SNAPSHOT_EN to add a snap-captured shadow bank that rd_data reads instead of the live counts.
module trig_counter_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIV_W  = 16,
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       ch_reset,
    input  logic [NUM_CH-1:0]       ch_load,
    input  logic [NUM_CH-1:0]       ch_up,
    input  logic [NUM_CH-1:0]       ch_down,
    input  logic [WIDTH-1:0]        load_value,
    input  logic                    saturate,
    input  logic [DIV_W-1:0]        prescale,
    input  logic [NUM_CH-1:0]       tc_clear,
    input  logic                    snap,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NUM_CH*WIDTH-1:0] count_flat,
    output logic [NUM_CH-1:0]       tc_flag
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_UP   = 2'b01,
        MODE_TRIG = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    logic [DIV_W-1:0]                r_pre_cnt;
    logic [NUM_CH-1:0][WIDTH-1:0]    r_cnt;
    logic [NUM_CH-1:0]               r_tc;
    logic [WIDTH-1:0]                r_rd;

    logic                            w_tick;
    logic [NUM_CH-1:0]               w_inc;
    logic [NUM_CH-1:0]               w_dec;
    logic [NUM_CH-1:0]               w_hit;
    logic [NUM_CH-1:0][WIDTH-1:0]    w_cnt_nxt;
    logic [NUM_CH-1:0][WIDTH-1:0]    w_rd_src;
    logic [WIDTH-1:0]                w_rd_nxt;

    assign w_tick = (r_pre_cnt == prescale);

    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_hit     = '0;
        w_cnt_nxt = r_cnt;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case (mode_e'(mode[2*i +: 2]))
                MODE_UP:   w_inc[i] = w_tick;
                MODE_DOWN: w_dec[i] = w_tick;
                MODE_TRIG: begin
                    w_inc[i] = ch_up[i] & ~ch_down[i];
                    w_dec[i] = ch_down[i] & ~ch_up[i];
                end
                default: ;
            endcase
            // A limit event only counts when the step actually wins priority.
            w_hit[i] = ~ch_reset[i] & ~ch_load[i] &
                       ((w_inc[i] & (r_cnt[i] == '1)) | (w_dec[i] & (r_cnt[i] == '0)));
            if (ch_reset[i])
                w_cnt_nxt[i] = '0;
            else if (ch_load[i])
                w_cnt_nxt[i] = load_value;
            else if (w_inc[i] && !(saturate && r_cnt[i] == '1))
                w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
            else if (w_dec[i] && !(saturate && r_cnt[i] == '0))
                w_cnt_nxt[i] = r_cnt[i] - WIDTH'(1);
        end
    end

`ifdef COUNTER_SNAPSHOT_EN
    logic [NUM_CH-1:0][WIDTH-1:0] r_shadow;

    always_ff @(posedge clk1) begin
        if (reset)
            r_shadow <= '0;
        else if (snap)
            r_shadow <= r_cnt;
    end

    assign w_rd_src = r_shadow;
`else
    logic w_snap_unused;
    assign w_snap_unused = snap;
    assign w_rd_src      = r_cnt;
`endif

    always_comb begin
        w_rd_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i))
                w_rd_nxt = w_rd_src[i];
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
            r_tc      <= '0;
            r_rd      <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + DIV_W'(1);
            r_cnt     <= w_cnt_nxt;
            r_tc      <= w_hit | (r_tc & ~tc_clear);
            r_rd      <= w_rd_nxt;
        end
    end

    assign count_flat = r_cnt;
    assign tc_flag    = r_tc;
    assign rd_data    = r_rd;

endmodule

// File: tb/tb_trig_counter_bank.sv
// Self-checking bench for trig_counter_bank: directed scenarios plus randomized stimulus against a behavioural model.
// Snapshot scenario runs only when COUNTER_SNAPSHOT_EN is defined.
module tb_trig_counter_bank;

    localparam int NC = 3;
    localparam int W  = 8;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int MAXV = (1 << W) - 1;

    logic            clk1 = 1'b0;
    logic            reset;
    logic [2*NC-1:0] mode;
    logic [NC-1:0]   ch_reset, ch_load, ch_up, ch_down, tc_clear;
    logic [W-1:0]    load_value;
    logic            saturate;
    logic [DW-1:0]   prescale;
    logic            snap;
    logic [SW-1:0]   rd_sel;
    logic [W-1:0]    rd_data;
    logic [NC*W-1:0] count_flat;
    logic [NC-1:0]   tc_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int        m_cnt[NC];
    int        m_shadow[NC];
    logic [NC-1:0] m_tc;
    int        m_pre;
    int        m_rd;

    always #5 clk1 = ~clk1;

    trig_counter_bank #(.NUM_CH(NC), .WIDTH(W), .DIV_W(DW)) dut (
        .clk1(clk1), .reset(reset), .mode(mode), .ch_reset(ch_reset),
        .ch_load(ch_load), .ch_up(ch_up), .ch_down(ch_down),
        .load_value(load_value), .saturate(saturate), .prescale(prescale),
        .tc_clear(tc_clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data),
        .count_flat(count_flat), .tc_flag(tc_flag)
    );

    function automatic logic [NC*W-1:0] model_flat();
        logic [NC*W-1:0] f;
        for (int c = 0; c < NC; c++) f[c*W +: W] = W'(m_cnt[c]);
        return f;
    endfunction

    function automatic int dut_ch(int c);
        return int'(count_flat[c*W +: W]);
    endfunction

    // Advance one clock: compute the model's next state from current inputs, then take the edge.
    task automatic clk_step();
        int  n_cnt[NC];
        int  n_shadow[NC];
        logic [NC-1:0] n_tc;
        int  n_pre, n_rd;
        bit  tick, up_req, dn_req, hit;
        int  md;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin n_cnt[c] = 0; n_shadow[c] = 0; end
            n_tc = '0; n_pre = 0; n_rd = 0;
        end else begin
            tick  = (m_pre == int'(prescale));
            n_pre = tick ? 0 : (m_pre + 1) % (1 << DW);
            for (int c = 0; c < NC; c++) begin
                md = int'(mode[2*c +: 2]);
                up_req = 0; dn_req = 0; hit = 0;
                if (md == 1) up_req = tick;
                if (md == 3) dn_req = tick;
                if (md == 2) begin
                    up_req = ch_up[c] && !ch_down[c];
                    dn_req = ch_down[c] && !ch_up[c];
                end
                if (ch_reset[c]) n_cnt[c] = 0;
                else if (ch_load[c]) n_cnt[c] = int'(load_value);
                else if (up_req) begin
                    if (m_cnt[c] == MAXV) begin hit = 1; n_cnt[c] = saturate ? MAXV : 0; end
                    else n_cnt[c] = m_cnt[c] + 1;
                end else if (dn_req) begin
                    if (m_cnt[c] == 0) begin hit = 1; n_cnt[c] = saturate ? 0 : MAXV; end
                    else n_cnt[c] = m_cnt[c] - 1;
                end else n_cnt[c] = m_cnt[c];
                n_tc[c] = hit ? 1'b1 : (tc_clear[c] ? 1'b0 : m_tc[c]);
                n_shadow[c] = snap ? m_cnt[c] : m_shadow[c];
            end
`ifdef COUNTER_SNAPSHOT_EN
            n_rd = (int'(rd_sel) < NC) ? m_shadow[rd_sel] : 0;
`else
            n_rd = (int'(rd_sel) < NC) ? m_cnt[rd_sel] : 0;
`endif
        end
        @(posedge clk1);
        #1;
        m_cnt = n_cnt; m_shadow = n_shadow; m_tc = n_tc; m_pre = n_pre; m_rd = n_rd;
    endtask

    task automatic clear_pulses();
        ch_reset = '0; ch_load = '0; ch_up = '0; ch_down = '0; tc_clear = '0; snap = 1'b0;
    endtask

    task automatic do_reset();
        clear_pulses();
        reset = 1'b1;
        repeat (3) clk_step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 6'b111001; ch_up = '1; ch_load = '1; load_value = 8'hA5;
        prescale = '0; saturate = 1'b0; tc_clear = '0; ch_reset = '0; ch_down = '0;
        snap = 1'b1; rd_sel = '0;
        repeat (3) clk_step();
        n_checks++;
        if (count_flat !== '0) begin n_fail++; $display("FAIL reset_count got %h want 0", count_flat); end
        n_checks++;
        if (tc_flag !== '0) begin n_fail++; $display("FAIL reset_tc got %b want 0", tc_flag); end
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd_data); end
        clear_pulses();
    endtask

    task automatic test_free_up();
        mode = 6'b010101; prescale = '0; saturate = 1'b0;
        do_reset();
        repeat (10) clk_step();
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (dut_ch(c) !== 10) begin n_fail++; $display("FAIL free_up_ch%0d got %0d want 10", c, dut_ch(c)); end
        end
        n_checks++;
        if (tc_flag !== '0) begin n_fail++; $display("FAIL free_up_tc got %b want 0", tc_flag); end
    endtask

    task automatic test_prescale();
        mode = 6'b000001; prescale = 8'd3;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            clk_step();
            n_checks++;
            if (dut_ch(0) !== k / 4) begin n_fail++; $display("FAIL prescale_ch0 cyc%0d got %0d want %0d", k, dut_ch(0), k / 4); end
        end
        // Lower prescale below the running prescaler count: next tick only after wrap.
        mode = 6'b110001; prescale = 8'd10;
        repeat (5) clk_step();
        prescale = 8'd2;
        for (int k = 0; k < 300; k++) begin
            clk_step();
            n_checks++;
            if (count_flat !== model_flat()) begin n_fail++; $display("FAIL prescale_lower cyc%0d got %h want %h", k, count_flat, model_flat()); end
        end
    endtask

    task automatic test_limits();
        mode = 6'b001000; saturate = 1'b0;
        do_reset();
        load_value = 8'hFE; ch_load = 3'b010; clk_step(); clear_pulses();
        ch_up = 3'b010; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(1) !== 8'hFF || tc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_step1 got %h/%b want ff/0", dut_ch(1), tc_flag[1]); end
        ch_up = 3'b010; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(1) !== 0 || tc_flag[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_step2 got %h/%b want 00/1", dut_ch(1), tc_flag[1]); end
        tc_clear = 3'b010; clk_step(); clear_pulses();
        n_checks++;
        if (tc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_tc_clear got %b want 0", tc_flag[1]); end
        ch_down = 3'b010; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(1) !== 8'hFF || tc_flag[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_down got %h/%b want ff/1", dut_ch(1), tc_flag[1]); end
        tc_clear = 3'b010; saturate = 1'b1;
        ch_load = 3'b010; clk_step(); clear_pulses();
        ch_up = 3'b010; clk_step();
        n_checks++;
        if (dut_ch(1) !== 8'hFF || tc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL sat_step1 got %h/%b want ff/0", dut_ch(1), tc_flag[1]); end
        clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(1) !== 8'hFF || tc_flag[1] !== 1'b1) begin n_fail++; $display("FAIL sat_step2 got %h/%b want ff/1", dut_ch(1), tc_flag[1]); end
        tc_clear = 3'b010; clk_step(); clear_pulses();
        n_checks++;
        if (tc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL sat_tc_clear got %b want 0", tc_flag[1]); end
        saturate = 1'b0;
    endtask

    task automatic test_priority();
        mode = 6'b100000;
        do_reset();
        load_value = 8'h55; ch_load = 3'b100; clk_step(); clear_pulses();
        ch_up = 3'b100; ch_down = 3'b100; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(2) !== 8'h55) begin n_fail++; $display("FAIL up_down_hold got %h want 55", dut_ch(2)); end
        ch_reset = 3'b100; ch_load = 3'b100; ch_up = 3'b100; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(2) !== 0) begin n_fail++; $display("FAIL reset_wins got %h want 00", dut_ch(2)); end
        load_value = 8'h3C; ch_load = 3'b100; ch_up = 3'b100; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(2) !== 8'h3C) begin n_fail++; $display("FAIL load_wins got %h want 3c", dut_ch(2)); end
        // Load in off mode, then a ch_reset must not touch a set tc flag.
        mode = 6'b000000; load_value = 8'h77; ch_load = 3'b001; clk_step(); clear_pulses();
        n_checks++;
        if (dut_ch(0) !== 8'h77) begin n_fail++; $display("FAIL load_off_mode got %h want 77", dut_ch(0)); end
        mode = 6'b100000; ch_down = 3'b100; load_value = 8'h00; ch_load = 3'b000;
        ch_reset = 3'b100; clk_step(); clear_pulses();
        ch_down = 3'b100; clk_step(); clear_pulses();
        ch_reset = 3'b100; clk_step(); clear_pulses();
        n_checks++;
        if (tc_flag[2] !== 1'b1 || dut_ch(2) !== 0) begin n_fail++; $display("FAIL ch_reset_keeps_tc got %b/%h want 1/00", tc_flag[2], dut_ch(2)); end
    endtask

    task automatic test_tc_set_wins();
        mode = 6'b000010; saturate = 1'b0;
        do_reset();
        load_value = 8'hFF; ch_load = 3'b001; clk_step(); clear_pulses();
        ch_up = 3'b001; clk_step(); clear_pulses();
        ch_load = 3'b001; clk_step(); clear_pulses();
        ch_up = 3'b001; tc_clear = 3'b001; clk_step(); clear_pulses();
        n_checks++;
        if (tc_flag[0] !== 1'b1 || dut_ch(0) !== 0) begin n_fail++; $display("FAIL set_beats_clear got %b/%h want 1/00", tc_flag[0], dut_ch(0)); end
`ifndef COUNTER_SNAPSHOT_EN
        load_value = 8'h9A; ch_load = 3'b010; clk_step(); clear_pulses();
        rd_sel = 2'd1; clk_step();
        n_checks++;
        if (rd_data !== 8'h9A) begin n_fail++; $display("FAIL rd_live got %h want 9a", rd_data); end
`endif
        rd_sel = 2'd3; clk_step();
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL rd_out_of_range got %h want 00", rd_data); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            mode       = 6'($urandom);
            ch_reset   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : '0;
            ch_load    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : '0;
            ch_up      = 3'($urandom);
            ch_down    = 3'($urandom);
            tc_clear   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : '0;
            load_value = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 5));
            saturate   = 1'($urandom);
            prescale   = 8'($urandom_range(0, 3));
            snap       = ($urandom_range(0, 7) == 0);
            rd_sel     = 2'($urandom);
            clk_step();
            n_checks++;
            if (count_flat !== model_flat() || tc_flag !== m_tc || rd_data !== W'(m_rd)) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h/%b/%h want %h/%b/%h", k, count_flat, tc_flag, rd_data,
                         model_flat(), m_tc, W'(m_rd));
            end
        end
        reset = 1'b0;
        clear_pulses();
    endtask

`ifdef COUNTER_SNAPSHOT_EN
    task automatic test_snapshot();
        mode = 6'b000001; prescale = '0; rd_sel = '0;
        do_reset();
        repeat (100) clk_step();
        snap = 1'b1; clk_step(); snap = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            n_checks++;
            if (rd_data !== 8'd100 || dut_ch(0) <= 100) begin
                n_fail++; $display("FAIL snap_hold got rd %0d live %0d want rd 100 live >100", rd_data, dut_ch(0));
            end
        end
        reset = 1'b1; clk_step(); reset = 1'b0;
        n_checks++;
        if (count_flat !== '0 || rd_data !== '0) begin n_fail++; $display("FAIL snap_reset got %h/%h want 0/0", count_flat, rd_data); end
        clk_step();
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL snap_shadow_cleared got %h want 00", rd_data); end
    endtask
`endif

    initial begin
        for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_shadow[c] = 0; end
        m_tc = '0; m_pre = 0; m_rd = 0;
        test_reset();
        test_free_up();
        test_prescale();
        test_limits();
        test_priority();
        test_tc_set_wins();
        test_random();
`ifdef COUNTER_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
